// File: rtl/state_timer_pkg.sv
// Shared constants for the train-controller blocks: timer FSM encoding,
// 4-bit train state codes and the millisecond field width.
package state_timer_pkg;

  localparam int STATE_W = 4;
  localparam int MS_W    = 13;

  typedef logic [STATE_W-1:0] train_state_t;
  typedef logic [MS_W-1:0]    ms_t;

  // Train controller state codes (dwell times come from the parameter lookup)
  localparam train_state_t TS_HOME   = 4'b0000;
  localparam train_state_t TS_ACCEL  = 4'b0001;
  localparam train_state_t TS_CRUISE = 4'b0010;
  localparam train_state_t TS_BRAKE  = 4'b0011;
  localparam train_state_t TS_DOORS  = 4'b0100;

  // Dwell timer FSM
  typedef enum logic [2:0] {
    TMR_SYNC  = 3'd0,
    TMR_LOAD  = 3'd1,
    TMR_COUNT = 3'd2,
    TMR_DONE  = 3'd3,
    TMR_IDLE  = 3'd4
  } tmr_state_e;

endpackage

// File: rtl/state_timer_prescaler.sv
// Clock-cycle prescaler: produces a one-cycle tick every TICKS_PER_MS
// enabled cycles. clear has priority and suppresses the tick.
module ms_prescaler #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  // Cycle counter: wraps at LAST, freezes when not enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/state_timer.sv
// Per-state dwell timer: restarts on every change of present_state, counts
// the looked-up dwell down in ms and pulses timeout once when it expires.
module state_timer
  import state_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int TICKS_PER_MS = CLK_FREQ_HZ / 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      present_state,
  input  logic [MS_W-1:0] t,
  input  logic            pause,
  output logic            timeout,
  output logic            busy,
  output logic [MS_W-1:0] remaining_ms
);

  tmr_state_e   state, state_nxt;
  train_state_t prev_state;
  logic         change;
  logic         ms_tick;
  logic         pre_clear;
  logic         pre_en;

  assign change    = (present_state != prev_state);
  assign pre_clear = change || (state != TMR_COUNT);
  assign pre_en    = (state == TMR_COUNT) && !pause;
  assign busy      = (state == TMR_COUNT);
  assign timeout   = (state == TMR_DONE);

  ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clear  (pre_clear),
    .enable (pre_en),
    .tick   (ms_tick)
  );

  // Change detector: reset value 0000 means state 0000 needs no change to time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_state <= TS_HOME;
    else       prev_state <= present_state;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TMR_SYNC;
    else       state <= state_nxt;
  end

  // Next state: a change overrides everything, including the final ms tick
  always_comb begin
    state_nxt = state;
    if (change) begin
      state_nxt = TMR_LOAD;
    end else begin
      unique case (state)
        TMR_SYNC:  state_nxt = TMR_LOAD;
        TMR_LOAD:  state_nxt = (t == '0) ? TMR_IDLE : TMR_COUNT;
        TMR_COUNT: if (ms_tick && remaining_ms == MS_W'(1)) state_nxt = TMR_DONE;
        TMR_DONE:  state_nxt = TMR_IDLE;
        TMR_IDLE:  state_nxt = TMR_IDLE;
        default:   state_nxt = TMR_SYNC;
      endcase
    end
  end

  // Remaining-ms counter: loaded in LOAD, decremented on ms ticks, 0 otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_ms <= '0;
    end else if (change) begin
      remaining_ms <= '0;
    end else begin
      unique case (state)
        TMR_LOAD:  remaining_ms <= t;
        TMR_COUNT: if (ms_tick && remaining_ms != '0) remaining_ms <= remaining_ms - 1'b1;
        default:   remaining_ms <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_state_timer.sv
// Directed bench for state_timer with TICKS_PER_MS=4 and a registered
// dwell lookup: 0000->2000, 0011->1000, 0100->2000, others->0.
module tb_state_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  present_state;
  logic [12:0] t;
  logic        pause;
  logic        timeout;
  logic        busy;
  logic [12:0] remaining_ms;

  int errors = 0;
  int checks = 0;
  logic seen;

  always #5 clk = ~clk;

  state_timer #(.CLK_FREQ_HZ(4000), .TICKS_PER_MS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .present_state (present_state),
    .t             (t),
    .pause         (pause),
    .timeout       (timeout),
    .busy          (busy),
    .remaining_ms  (remaining_ms)
  );

  function automatic logic [12:0] lut(input logic [3:0] s);
    case (s)
      4'b0000: return 13'd2000;
      4'b0011: return 13'd1000;
      4'b0100: return 13'd2000;
      default: return 13'd0;
    endcase
  endfunction

  // Registered parameter lookup
  always @(posedge clk) t <= lut(present_state);

  // Advance n edges, land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; present_state = 4'b0000; pause = 1'b0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining_ms, 0);
    chk("rst_to", timeout, 0);

    // Scenario 1: release with 0000, timeout after edge 8002
    reset = 1'b0;
    step(1);    chk("s1_busy_e1", busy, 0);
    step(1);    chk("s1_busy_e2", busy, 1);
                chk("s1_rem_e2", remaining_ms, 2000);
    step(4);    chk("s1_rem_e6", remaining_ms, 1999);
    step(7995); chk("s1_to_e8001", timeout, 0);
                chk("s1_rem_e8001", remaining_ms, 1);
    step(1);    chk("s1_to_e8002", timeout, 1);
                chk("s1_busy_e8002", busy, 0);
                chk("s1_rem_e8002", remaining_ms, 0);
    step(1);    chk("s1_to_off", timeout, 0);

    // Scenario 2: change to 0011, timeout after edge N+4001
    present_state = 4'b0011;
    step(1);    chk("s2_load_busy", busy, 0);
    step(1);    chk("s2_rem_n1", remaining_ms, 1000);
                chk("s2_busy_n1", busy, 1);
    step(3999); chk("s2_to_n4000", timeout, 0);
    step(1);    chk("s2_to_n4001", timeout, 1);
                chk("s2_busy_to", busy, 0);
    step(1);    chk("s2_to_off", timeout, 0);

    // Scenario 3: untimed state 0001
    present_state = 4'b0001;
    step(2);    chk("s3_busy", busy, 0);
                chk("s3_rem", remaining_ms, 0);
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      step(1);
      if (timeout) seen = 1'b1;
    end
    chk("s3_no_to", seen, 0);

    // Scenario 4: 0100 with 100-cycle pause mid-count
    present_state = 4'b0100;
    step(2);    chk("s4_rem_n1", remaining_ms, 2000);
    step(100);  chk("s4_rem_n101", remaining_ms, 1975);
    pause = 1'b1;
    step(50);   chk("s4_rem_p50", remaining_ms, 1975);
                chk("s4_busy_p50", busy, 1);
    step(50);   chk("s4_rem_p100", remaining_ms, 1975);
    pause = 1'b0;
    step(7899); chk("s4_to_n8100", timeout, 0);
    step(1);    chk("s4_to_n8101", timeout, 1);

    // Scenario 5: change coincident with the final ms tick
    step(1);
    present_state = 4'b0011;
    step(2);    chk("s5_rem_n1", remaining_ms, 1000);
    step(3999); chk("s5_rem_n4000", remaining_ms, 1);
    present_state = 4'b0100;
    step(1);    chk("s5_no_to", timeout, 0);
                chk("s5_busy_load", busy, 0);
    step(1);    chk("s5_rem_reload", remaining_ms, 2000);
                chk("s5_to_after", timeout, 0);

    // Scenario 6: reset mid-count in 0000, asynchronous clear
    present_state = 4'b0000;
    step(2);    chk("s6_rem_start", remaining_ms, 2000);
    step(50);
    reset = 1'b1;
    #2;
    chk("s6_async_busy", busy, 0);
    chk("s6_async_rem", remaining_ms, 0);
    chk("s6_async_to", timeout, 0);
    step(3);    chk("s6_hold_to", timeout, 0);
    reset = 1'b0;
    step(1);    chk("s6_busy_e1", busy, 0);
    step(1);    chk("s6_busy_e2", busy, 1);
                chk("s6_rem_e2", remaining_ms, 2000);
    step(7999); chk("s6_to_e8001", timeout, 0);
    step(1);    chk("s6_to_e8002", timeout, 1);
    step(1);    chk("s6_to_off", timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
